// File: rtl/lfm_pulse_scheduler.sv
// CPI sequencer for the IF LFM pulse generator: drives the waveform ROM address, the
// transmit gate (aligned to the ROM's registered q), the PRT sync strobe and the receive window.
module lfm_pulse_scheduler #(
    parameter int CW = 14,
    parameter int AW = 10,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] pri_len,
    input  logic [AW:0]   pulse_len,
    input  logic [CW-1:0] rx_start,
    input  logic [CW-1:0] rx_len,
    input  logic [NW-1:0] n_pulses,
    output logic          busy,
    output logic          cfg_err,
    output logic [AW-1:0] rom_addr,
    output logic          tx_en,
    output logic          prt_sync,
    output logic          rx_gate,
    output logic [NW-1:0] pulse_idx,
    output logic          cpi_done
);

    // Common width for comparing the CW-bit counter against the (AW+1)-bit pulse length.
    localparam int XW = ((CW > AW + 1) ? CW : AW + 1) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] idx_q, idx_d;
    logic          tx_en_q, tx_en_d;
    logic          cfg_err_q, cfg_err_d;

    logic [CW-1:0] pri_len_q, pri_len_d;
    logic [AW:0]   pulse_len_q, pulse_len_d;
    logic [CW-1:0] rx_start_q, rx_start_d;
    logic [CW-1:0] rx_len_q, rx_len_d;
    logic [NW-1:0] n_pulses_q, n_pulses_d;

    logic          cfg_ok;
    logic          in_pulse;
    logic          rx_hit;
    logic [CW:0]   rx_off;
    logic          in_run;

    always_comb begin
        cfg_ok = (n_pulses != '0)
              && (pulse_len != '0)
              && (XW'(pulse_len) <= (XW'(1) << AW))
              && (XW'(pri_len) > XW'(pulse_len));
    end

    // Window test in CW+1 bits; the cnt>=rx_start term keeps the subtraction from wrapping.
    always_comb begin
        in_pulse = XW'(cnt_q) < XW'(pulse_len_q);
        rx_off   = {1'b0, cnt_q} - {1'b0, rx_start_q};
        rx_hit   = (cnt_q >= rx_start_q) && (rx_off < {1'b0, rx_len_q});
        in_run   = (state_q == RUN);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        cfg_err_d   = 1'b0;
        pri_len_d   = pri_len_q;
        pulse_len_d = pulse_len_q;
        rx_start_d  = rx_start_q;
        rx_len_d    = rx_len_q;
        n_pulses_d  = n_pulses_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (start) begin
                    if (cfg_ok) begin
                        pri_len_d   = pri_len;
                        pulse_len_d = pulse_len;
                        rx_start_d  = rx_start;
                        rx_len_d    = rx_len;
                        n_pulses_d  = n_pulses;
                        state_d     = RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt_q == pri_len_q - CW'(1)) begin
                    cnt_d = '0;
                    if (idx_q == n_pulses_q - NW'(1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + NW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end

        // Masking with the next state lets an abort drop tx_en on the very next cycle.
        tx_en_d = in_run && (state_d == RUN) && in_pulse;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            tx_en_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            tx_en_q   <= tx_en_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Latched configuration is only consumed in RUN, so it needs no reset.
    always_ff @(posedge clk) begin
        pri_len_q   <= pri_len_d;
        pulse_len_q <= pulse_len_d;
        rx_start_q  <= rx_start_d;
        rx_len_q    <= rx_len_d;
        n_pulses_q  <= n_pulses_d;
    end

    always_comb begin
        busy      = (state_q != IDLE);
        cfg_err   = cfg_err_q;
        rom_addr  = (in_run && in_pulse) ? cnt_q[AW-1:0] : '0;
        tx_en     = tx_en_q;
        prt_sync  = in_run && (cnt_q == '0);
        rx_gate   = in_run && rx_hit;
        pulse_idx = in_run ? idx_q : '0;
        cpi_done  = (state_q == DONE);
    end

endmodule

// File: tb/tb_lfm_pulse_scheduler.sv
// Scoreboard bench for lfm_pulse_scheduler: per-cycle expected outputs are queued as
// stimulus is driven and popped for comparison after each rising edge.
module tb_lfm_pulse_scheduler;

    localparam int CW = 14;
    localparam int AW = 10;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [CW-1:0] pri_len, rx_start, rx_len;
    logic [AW:0]   pulse_len;
    logic [NW-1:0] n_pulses;
    logic          busy, cfg_err, tx_en, prt_sync, rx_gate, cpi_done;
    logic [AW-1:0] rom_addr;
    logic [NW-1:0] pulse_idx;

    always #5 clk = ~clk;

    lfm_pulse_scheduler #(.CW(CW), .AW(AW), .NW(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .pri_len   (pri_len),
        .pulse_len (pulse_len),
        .rx_start  (rx_start),
        .rx_len    (rx_len),
        .n_pulses  (n_pulses),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .rom_addr  (rom_addr),
        .tx_en     (tx_en),
        .prt_sync  (prt_sync),
        .rx_gate   (rx_gate),
        .pulse_idx (pulse_idx),
        .cpi_done  (cpi_done)
    );

    typedef struct packed {
        logic          busy;
        logic          cfg_err;
        logic [AW-1:0] rom_addr;
        logic          tx_en;
        logic          prt_sync;
        logic          rx_gate;
        logic [NW-1:0] pulse_idx;
        logic          cpi_done;
    } outs_t;

    outs_t exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic outs_t idle_out();
        outs_t e;
        e = '0;
        return e;
    endfunction

    // Expected outputs k cycles after the start edge (k=1 is the first RUN cycle).
    function automatic outs_t exp_cpi(input int k, input int pri, input int pl,
                                      input int rxs, input int rxl, input int n);
        outs_t e;
        int    total, c, p;
        e     = '0;
        total = n * pri;
        if (k >= 1 && k <= total) begin
            c = (k - 1) % pri;
            p = (k - 1) / pri;
            e.busy      = 1'b1;
            if (c < pl) e.rom_addr = c[AW-1:0];
            e.prt_sync  = (c == 0);
            e.rx_gate   = (c >= rxs) && (c - rxs < rxl);
            e.pulse_idx = p[NW-1:0];
        end else if (k == total + 1) begin
            e.busy     = 1'b1;
            e.cpi_done = 1'b1;
        end
        if (k >= 2 && k <= total + 1 && ((k - 2) % pri) < pl) e.tx_en = 1'b1;
        return e;
    endfunction

    task automatic cycle(input string tag, input outs_t e);
        outs_t x;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        cyc++;
        x = exp_q.pop_front();
        t = $sformatf("%s[%0d]", tag_q.pop_front(), cyc);
        check_eq({t, ".busy"},      busy,      x.busy);
        check_eq({t, ".cfg_err"},   cfg_err,   x.cfg_err);
        check_eq({t, ".rom_addr"},  rom_addr,  x.rom_addr);
        check_eq({t, ".tx_en"},     tx_en,     x.tx_en);
        check_eq({t, ".prt_sync"},  prt_sync,  x.prt_sync);
        check_eq({t, ".rx_gate"},   rx_gate,   x.rx_gate);
        check_eq({t, ".pulse_idx"}, pulse_idx, x.pulse_idx);
        check_eq({t, ".cpi_done"},  cpi_done,  x.cpi_done);
    endtask

    task automatic set_cfg(input int pri, input int pl, input int rxs, input int rxl, input int n);
        pri_len   = CW'(pri);
        pulse_len = (AW + 1)'(pl);
        rx_start  = CW'(rxs);
        rx_len    = CW'(rxl);
        n_pulses  = NW'(n);
    endtask

    // Starts a CPI and checks kmax cycles; chg_k>0 scrambles config and pulses start mid-run.
    task automatic run_cpi(input string tag, input int pri, input int pl, input int rxs,
                           input int rxl, input int n, input int kmax, input int chg_k);
        set_cfg(pri, pl, rxs, rxl, n);
        start = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            if (k == 2) start = 1'b0;
            if (chg_k > 0 && k == chg_k) begin
                set_cfg(5, 2, 0, 1, 1);
                start = 1'b1;
            end
            if (chg_k > 0 && k == chg_k + 1) start = 1'b0;
            cycle(tag, exp_cpi(k, pri, pl, rxs, rxl, n));
        end
        start = 1'b0;
    endtask

    int bad_pri [4] = '{8, 20, 20, 2000};
    int bad_pl  [4] = '{8, 8, 0, 1025};
    int bad_n   [4] = '{3, 0, 3, 1};

    initial begin
        outs_t err;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(20, 8, 10, 6, 3);
        cycle("reset", idle_out());
        cycle("reset", idle_out());
        rst = 1'b1;
        cycle("idle", idle_out());

        run_cpi("nominal", 20, 8, 10, 6, 3, 62, 0);
        run_cpi("b2b", 12, 3, 2, 4, 2, 26, 0);

        err = '0;
        err.cfg_err = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cfg(bad_pri[i], bad_pl[i], 0, 1, bad_n[i]);
            start = 1'b1;
            cycle($sformatf("bad_cfg%0d", i), err);
            start = 1'b0;
            cycle($sformatf("bad_cfg%0d", i), idle_out());
        end

        run_cpi("abort", 20, 8, 10, 6, 3, 25, 0);
        abort = 1'b1;
        cycle("abort", idle_out());
        abort = 1'b0;
        cycle("abort", idle_out());
        run_cpi("post_abort", 20, 8, 10, 6, 3, 62, 0);

        run_cpi("abort_wrap", 12, 3, 2, 4, 2, 24, 0);
        abort = 1'b1;
        cycle("abort_wrap", idle_out());
        abort = 1'b0;
        cycle("abort_wrap", idle_out());

        run_cpi("rst_run", 20, 8, 10, 6, 3, 6, 0);
        rst = 1'b0;
        cycle("rst_run", idle_out());
        start = 1'b1;
        cycle("rst_start", idle_out());
        start = 1'b0;
        rst   = 1'b1;
        cycle("rst_rel", idle_out());
        run_cpi("post_rst", 12, 3, 2, 4, 2, 26, 0);

        run_cpi("cfg_stable", 20, 8, 10, 6, 3, 62, 5);

        run_cpi("edge", 16383, 1024, 16380, 100, 1, 16385, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
